// File: rtl/pong_score_display.sv
// PONG score keeper: two-digit BCD scores per player, win detection, and a
// four-slot multiplexed digit scanner with leading-zero blanking and game-over blink.
module pong_score_display #(
    parameter int SCAN_DIV     = 50000,
    parameter int WIN_SCORE    = 11,
    parameter int BLINK_FRAMES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       point_p1,
    input  logic       point_p2,
    input  logic       new_game,
    output logic [3:0] digit,
    output logic [3:0] an_n,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int SCW = $clog2(SCAN_DIV);
    localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

    typedef enum logic {PLAY, OVER} state_t;

    // Scores are held as {tens, units} BCD pairs; 99 saturates.
    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        if (s == 8'h99)
            return s;
        else if (s[3:0] == 4'd9)
            return {s[7:4] + 4'd1, 4'd0};
        else
            return {s[7:4], s[3:0] + 4'd1};
    endfunction

    state_t     state_q, state_d;
    logic [7:0] p1_q, p1_d, p2_q, p2_d;
    logic [7:0] p1_inc, p2_inc;
    logic [1:0] winner_q, winner_d;

    logic [SCW-1:0] scan_cnt;
    logic [1:0]     slot;
    logic [FCW-1:0] frame_cnt;
    logic           hidden;
    logic           scan_wrap, frame_wrap;

    logic [3:0] sel_digit, an_d;
    logic       winner_slot, blank;

    assign p1_inc = bcd_inc(p1_q);
    assign p2_inc = bcd_inc(p2_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= PLAY;
            p1_q     <= '0;
            p2_q     <= '0;
            winner_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            winner_q <= winner_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        winner_d = winner_q;
        if (new_game) begin
            state_d  = PLAY;
            p1_d     = '0;
            p2_d     = '0;
            winner_d = 2'b00;
        end else if (state_q == PLAY) begin
            // Simultaneous pulses are an invalid rally event and count for nobody.
            if (point_p1 && !point_p2) begin
                p1_d = p1_inc;
                if (p1_inc == WIN_BCD) begin
                    state_d  = OVER;
                    winner_d = 2'b01;
                end
            end else if (point_p2 && !point_p1) begin
                p2_d = p2_inc;
                if (p2_inc == WIN_BCD) begin
                    state_d  = OVER;
                    winner_d = 2'b10;
                end
            end
        end
    end

    assign game_over  = (state_q == OVER);
    assign winner     = winner_q;
    assign scan_wrap  = (scan_cnt == SCW'(SCAN_DIV - 1));
    assign frame_wrap = scan_wrap && (slot == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            slot     <= 2'd0;
        end else if (scan_wrap) begin
            scan_cnt <= '0;
            slot     <= slot + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Blink only runs while the game is over; a restart snaps it back to visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            hidden    <= 1'b0;
        end else if (new_game || state_q != OVER) begin
            frame_cnt <= '0;
            hidden    <= 1'b0;
        end else if (frame_wrap) begin
            if (frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                hidden    <= ~hidden;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        sel_digit = 4'h0;
        case (slot)
            2'd0: sel_digit = p1_q[7:4];
            2'd1: sel_digit = p1_q[3:0];
            2'd2: sel_digit = p2_q[7:4];
            2'd3: sel_digit = p2_q[3:0];
            default: sel_digit = 4'h0;
        endcase
        winner_slot = slot[1] ? winner_q[1] : winner_q[0];
        blank       = (!slot[0] && sel_digit == 4'h0) || (hidden && winner_slot);
        an_d        = blank ? 4'b1111 : ~(4'b0001 << (2'd3 - slot));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= 4'h0;
            an_n  <= 4'b1111;
        end else begin
            digit <= sel_digit;
            an_n  <= an_d;
        end
    end

endmodule
